// File: rtl/bus_led_ctrl.sv
// Memory-mapped LED controller with static, blink and prescaled-phase control per channel.
// Define BUS_LED_PWM_EN to add per-channel 8-bit DUTY brightness registers gated by a free-running PWM.
module bus_led_ctrl #(
  parameter logic [31:0] ADDR       = 32'h0300_0000,
  parameter int unsigned NCH        = 8,
  parameter int unsigned CW         = 24,
  parameter int unsigned PERIOD_RST = 12000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    bus_addr,
  input  logic [31:0]    bus_wr_data,
  input  logic [3:0]     bus_we,
  input  logic           bus_re,
  output logic [31:0]    bus_rd_data,
  output logic           bus_ack,
  output logic [NCH-1:0] leds
);

  localparam logic [CW-1:0] PERIOD_INIT = CW'(PERIOD_RST);

  function automatic logic [NCH-1:0] phase_init();
    logic [NCH-1:0] p;
    for (int unsigned i = 0; i < NCH; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  logic [NCH-1:0] static_r, blink_r, phase_r, led_next;
  logic [CW-1:0]  period_r, cnt_r;
  logic           tick_r;
  logic           hit, wr, rd, tick_clr;
  logic [5:0]     off;
  logic [31:0]    wmask, static_ext, blink_ext, period_ext, status_ext, rd_mux;
  logic [31:0]    static_new, blink_new, period_new;

`ifdef BUS_LED_PWM_EN
  localparam int unsigned DW = (NCH > 1) ? $clog2(NCH) : 1;
  logic [7:0]    duty_r [NCH];
  logic [7:0]    pwm_r;
  logic          duty_hit;
  logic [DW-1:0] didx;
`endif

  assign off      = bus_addr[7:2];
  assign hit      = (bus_addr[31:8] == ADDR[31:8]) && (bus_re || (|bus_we));
  assign wr       = hit && (|bus_we);
  assign rd       = hit && bus_re && !(|bus_we);
  assign tick_clr = wr && (off == 6'd3) && bus_we[0] && bus_wr_data[0];

  always_comb begin
    wmask      = {{8{bus_we[3]}}, {8{bus_we[2]}}, {8{bus_we[1]}}, {8{bus_we[0]}}};
    static_ext = '0;
    blink_ext  = '0;
    period_ext = '0;
    status_ext = '0;
    static_ext[NCH-1:0] = static_r;
    blink_ext[NCH-1:0]  = blink_r;
    period_ext[CW-1:0]  = period_r;
    status_ext[0]       = tick_r;
    // PHASE bits that would land above bit 31 (NCH > 24) are not readable.
    for (int unsigned i = 0; i < NCH && i < 24; i++) status_ext[i+8] = phase_r[i];
    static_new = (static_ext & ~wmask) | (bus_wr_data & wmask);
    blink_new  = (blink_ext  & ~wmask) | (bus_wr_data & wmask);
    period_new = (period_ext & ~wmask) | (bus_wr_data & wmask);
`ifdef BUS_LED_PWM_EN
    duty_hit = (off >= 6'd16) && ((32'(off) - 32'd16) < NCH);
    didx     = DW'(off - 6'd16);
`endif
    case (off)
      6'd0:    rd_mux = static_ext;
      6'd1:    rd_mux = blink_ext;
      6'd2:    rd_mux = period_ext;
      6'd3:    rd_mux = status_ext;
      default: rd_mux = '0;
    endcase
`ifdef BUS_LED_PWM_EN
    if (duty_hit) rd_mux = {24'd0, duty_r[didx]};
`endif
    led_next = static_r ^ (blink_r & phase_r);
`ifdef BUS_LED_PWM_EN
    for (int unsigned i = 0; i < NCH; i++) led_next[i] = led_next[i] & (pwm_r < duty_r[i]);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      static_r    <= '0;
      blink_r     <= '0;
      period_r    <= PERIOD_INIT;
      cnt_r       <= PERIOD_INIT;
      phase_r     <= phase_init();
      tick_r      <= 1'b0;
      leds        <= '0;
      bus_ack     <= 1'b0;
      bus_rd_data <= '0;
`ifdef BUS_LED_PWM_EN
      pwm_r       <= '0;
      for (int unsigned i = 0; i < NCH; i++) duty_r[i] <= 8'hFF;
`endif
    end else begin
      bus_ack     <= hit;
      bus_rd_data <= rd ? rd_mux : '0;
      if (wr) begin
        case (off)
          6'd0:    static_r <= static_new[NCH-1:0];
          6'd1:    blink_r  <= blink_new[NCH-1:0];
          6'd2:    period_r <= period_new[CW-1:0];
          default: ;
        endcase
      end
      // A reload in the same cycle as a W1C keeps TICK set.
      if (cnt_r == '0) begin
        cnt_r   <= period_r;
        phase_r <= ~phase_r;
        tick_r  <= 1'b1;
      end else begin
        cnt_r <= cnt_r - 1'b1;
        if (tick_clr) tick_r <= 1'b0;
      end
      leds <= led_next;
`ifdef BUS_LED_PWM_EN
      pwm_r <= pwm_r + 8'd1;
      if (wr && duty_hit && bus_we[0]) duty_r[didx] <= bus_wr_data[7:0];
`endif
    end
  end

endmodule

// File: doc/bus_led_ctrl.md
BUS_LED_CTRL -- requirements
Module: bus_led_ctrl

Interface
REQ-001 Parameter ADDR, default 32'h0300_0000, base address of the 256-byte register window (ADDR[7:0] = 0).
REQ-002 Parameter NCH, default 8, channel count, legal range 1..32.
REQ-003 Parameter CW, default 24, prescaler counter width.
REQ-004 Parameter PERIOD_RST, default 12000000, PERIOD register reset value (must fit in CW bits).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 bus_addr  in  32  byte address; word-aligned accesses only.
REQ-008 bus_wr_data  in  32  write data.
REQ-009 bus_we  in  4  byte write strobes; single-cycle pulse per transaction.
REQ-010 bus_re  in  1  read request; single-cycle pulse per transaction.
REQ-011 bus_rd_data  out  32  read data; all-zero whenever bus_ack is low, so it is OR-combinable.
REQ-012 bus_ack  out  1  one-cycle acknowledge for reads and writes.
REQ-013 leds  out  NCH  registered LED drive.

Function
REQ-014 Hit = bus_addr[31:8] == ADDR[31:8] and (bus_re or |bus_we); on a miss, bus_ack and bus_rd_data stay 0.
REQ-015 On a hit, bus_ack is high exactly one cycle later; bus_rd_data is registered and valid in that same cycle.
REQ-016 If bus_re and bus_we are both asserted, the access is treated as a write; no read data is returned (bus_rd_data = 0).
REQ-017 Offset 0x00 STATIC is RW, bits [NCH-1:0]; offset 0x04 BLINK_EN is RW, bits [NCH-1:0]; offset 0x08 PERIOD is RW, bits [CW-1:0]; unused bits read 0.
REQ-018 Offset 0x0C STATUS: bit0 is the sticky TICK flag, write-1-to-clear; bits [NCH+7:8] read PHASE and are read-only.
REQ-019 Writes honour byte strobes: bus_we[k] updates bits [8k+7:8k] only.
REQ-020 Unmapped offsets inside the window are acked; reads return 0 and writes are ignored.
REQ-021 Prescaler CNT (CW bits): if CNT == 0, then CNT <= PERIOD, PHASE <= ~PHASE, TICK <= 1; otherwise CNT <= CNT - 1. PHASE therefore toggles every PERIOD+1 cycles.
REQ-022 A PERIOD write does not disturb CNT; the new value takes effect at the next reload. PERIOD = 0 toggles PHASE every cycle.
REQ-023 If a TICK set and a W1C clear happen in the same cycle, the set wins.
REQ-024 leds[i] <= STATIC[i] ^ (BLINK_EN[i] & PHASE[i]) [& PWM gate, see REQ-029]; a register write is visible on leds two cycles after the write strobe.

Reset
REQ-025 Reset values:
  - STATIC = 0, BLINK_EN = 0, PERIOD = PERIOD_RST, CNT = PERIOD_RST;
  - PHASE[i] = ~i[0] (0x55 pattern); TICK = 0;
  - leds = 0, bus_ack = 0, bus_rd_data = 0.
REQ-026 Reset asserted mid-transaction drops that transaction: no ack is issued and the write has no effect; reset overrides every other update in the same cycle.

Configuration
REQ-027 Macro BUS_LED_PWM_EN compiles in per-channel brightness control.
REQ-028 With BUS_LED_PWM_EN: DUTY[i] is an 8-bit RW register at offset 0x40+4*i, reset value 8'hFF; PWM is an 8-bit free-running counter, reset 0, that increments every cycle and wraps from 255 to 0.
REQ-029 With BUS_LED_PWM_EN: leds[i] is additionally ANDed with (PWM < DUTY[i]); DUTY = 0 forces the LED off and DUTY = 255 gives 255/256 on-time.
REQ-030 Without BUS_LED_PWM_EN: no DUTY or PWM logic exists, offsets 0x40+ behave per REQ-020, and leds follow REQ-024 ungated.

Verification
REQ-031 Required directed scenarios:
  - Reset, then read 0x08 and 0x0C (NCH=8) -> PERIOD reads PERIOD_RST; STATUS reads 0x0000_5500; leds == 0.
  - PERIOD=3, BLINK_EN=0xFF -> PHASE toggles every 4 cycles after the current CNT expires; TICK set; writing 1 to STATUS clears bit0.
  - Write STATIC=0x0F with bus_we=4'b0001, then with bus_we=4'b0010 -> first write takes effect (reads 0x0F); second is ignored (still reads 0x0F).
  - Read ADDR+0x20, then read ADDR+0x100 -> first: ack, data 0; second: no ack.
  - Assert reset the same cycle as a write to STATIC=0xAA -> no ack; STATIC == 0.
  - BUS_LED_PWM_EN, DUTY[0]=64, STATIC[0]=1 -> leds[0] is high for 64 of every 256 cycles; DUTY[0]=0 -> leds[0] is constantly low.
